// File: rtl/alu_seq_if.sv
// Request/response bundle for the sequential ALU: operands and opcode in,
// registered result, flags and status out.
interface alu_seq_if #(
  parameter int N = 19
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2:0]   ALUControl;
  logic [N-1:0] Result;
  logic [2:0]   ALUFlags;
  logic         dz;
  logic         err;
  logic         busy;
  logic         done;

  modport master (
    output start, A, B, ALUControl,
    input  Result, ALUFlags, dz, err, busy, done
  );

  modport slave (
    input  start, A, B, ALUControl,
    output Result, ALUFlags, dz, err, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: ADD/SUB/MUL/SHL/SHR/illegal complete in one cycle, while
// unsigned DIV/MOD run an N-step restoring shift-subtract divider.
module alu_seq #(
  parameter int N  = 19,
  parameter int CW = $clog2(N+1)
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ITER = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam logic [N-1:0] WIDTH_VAL = N'(N);

  typedef struct packed {
    logic [N-1:0] rem;
    logic [N-1:0] quo;
  } div_t;

  // One restoring step: shift the next dividend bit into the remainder and
  // keep the subtraction only when it does not borrow.
  function automatic div_t div_step(input div_t cur, input logic [N-1:0] dvs);
    div_t       nxt;
    logic [N:0] sh;
    logic [N:0] trial;
    sh      = {cur.rem, cur.quo[N-1]};
    trial   = sh - {1'b0, dvs};
    nxt.quo = {cur.quo[N-2:0], ~trial[N]};
    nxt.rem = trial[N] ? sh[N-1:0] : trial[N-1:0];
    return nxt;
  endfunction

  function automatic logic [2:0] flags_of(input logic [N-1:0] r, input logic v);
    return {r == '0, v, r[N-1]};
  endfunction

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  div_t          div_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  dvs_q;
  logic [2:0]    op_q;
  logic [N-1:0]  result_q;
  logic [2:0]    flags_q;
  logic          dz_q;
  logic          err_q;
  logic          busy_q;
  logic          done_q;

  logic [2*N-1:0] prod;
  logic [N-1:0]   res_c;
  logic           v_c;
  logic           err_c;
  logic [2:0]     flags_c;
  logic           is_iter_op;
  div_t           st_first;
  div_t           st_iter;
  logic           dvz;
  logic [N-1:0]   res_it;

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    prod  = {{N{1'b0}}, bus.A} * {{N{1'b0}}, bus.B};
    res_c = '0;
    v_c   = 1'b0;
    err_c = 1'b0;
    case (bus.ALUControl)
      OP_ADD: begin
        res_c = bus.A + bus.B;
        v_c   = (bus.A[N-1] == bus.B[N-1]) && (res_c[N-1] != bus.A[N-1]);
      end
      OP_SUB: begin
        res_c = bus.A - bus.B;
        v_c   = (bus.A[N-1] != bus.B[N-1]) && (res_c[N-1] != bus.A[N-1]);
      end
      OP_MUL: begin
        res_c = prod[N-1:0];
        v_c   = |prod[2*N-1:N];
      end
      OP_SHL: res_c = (bus.B < WIDTH_VAL) ? bus.A << bus.B : '0;
      OP_SHR: res_c = (bus.B < WIDTH_VAL) ? bus.A >> bus.B : '0;
      OP_ILL: err_c = 1'b1;
      default: ;
    endcase
    flags_c    = err_c ? 3'b000 : flags_of(res_c, v_c);
    is_iter_op = (bus.ALUControl == OP_DIV) || (bus.ALUControl == OP_MOD);
  end

  // The acceptance edge performs the first divider step, so the remaining
  // N-1 steps finish exactly N cycles after the request was taken.
  always_comb begin
    st_first = div_step({{N{1'b0}}, bus.A}, bus.B);
    st_iter  = div_step(div_q, dvs_q);
    dvz      = (dvs_q == '0);
    if (op_q == OP_DIV) res_it = dvz ? '1 : st_iter.quo;
    else                res_it = dvz ? a_q : st_iter.rem;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      div_q    <= '0;
      a_q      <= '0;
      dvs_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      dz_q     <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (is_iter_op) begin
              state  <= ITER;
              busy_q <= 1'b1;
              a_q    <= bus.A;
              dvs_q  <= bus.B;
              op_q   <= bus.ALUControl;
              div_q  <= st_first;
              cnt    <= CW'(N - 1);
            end else begin
              result_q <= res_c;
              flags_q  <= flags_c;
              dz_q     <= 1'b0;
              err_q    <= err_c;
              done_q   <= 1'b1;
            end
          end
        end
        ITER: begin
          div_q <= st_iter;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            result_q <= res_it;
            flags_q  <= flags_of(res_it, 1'b0);
            dz_q     <= dvz;
            err_q    <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Result   = result_q;
  assign bus.ALUFlags = flags_q;
  assign bus.dz       = dz_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (N=19): single-cycle ops, the
// iterative divider, divide-by-zero, ignored starts and reset mid-operation.
module tb_alu_seq;
  localparam int N = 19;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  alu_seq_if #(.N(N)) bus ();

  alu_seq #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a request for exactly one edge; returns 1 time unit after it.
  task automatic launch(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    bus.ALUControl = op;
    bus.A          = a;
    bus.B          = b;
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [N-1:0] res, input logic [2:0] flags,
                           input logic dz, input logic err);
    check({tag, " done"},   {31'b0, bus.done},     1);
    check({tag, " result"}, {13'b0, bus.Result},   {13'b0, res});
    check({tag, " flags"},  {29'b0, bus.ALUFlags}, {29'b0, flags});
    check({tag, " dz"},     {31'b0, bus.dz},       {31'b0, dz});
    check({tag, " err"},    {31'b0, bus.err},      {31'b0, err});
  endtask

  // Sample 1 is the one just after the acceptance edge; lat=0 means timeout.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) step();
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat;
  int bcnt;
  int dn;
  int first;
  int both;

  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.A          = '0;
    bus.B          = '0;
    bus.ALUControl = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", {13'b0, bus.Result},   0);
    check("reset flags",  {29'b0, bus.ALUFlags}, 0);
    check("reset dz",     {31'b0, bus.dz},       0);
    check("reset err",    {31'b0, bus.err},      0);
    check("reset busy",   {31'b0, bus.busy},     0);
    check("reset done",   {31'b0, bus.done},     0);

    // First start right after reset release is taken on the first edge.
    rst_n = 1'b1;
    launch(OP_ADD, 19'h3FFFF, 19'h00001);
    check_out("add ovf", 19'h40000, 3'b011, 1'b0, 1'b0);
    step();
    check("add done single pulse", {31'b0, bus.done}, 0);
    check("add result holds", {13'b0, bus.Result}, 32'h40000);

    launch(OP_SUB, 19'd5, 19'd5);
    check_out("sub zero", 19'h0, 3'b100, 1'b0, 1'b0);
    launch(OP_MUL, 19'h40000, 19'd2);
    check_out("mul ovf", 19'h0, 3'b110, 1'b0, 1'b0);
    launch(OP_SUB, 19'h40000, 19'd1);
    check_out("sub ovf", 19'h3FFFF, 3'b010, 1'b0, 1'b0);

    // Start held high: accepted every cycle, done stays high.
    bus.ALUControl = OP_ADD; bus.A = 19'd1; bus.B = 19'd2; bus.start = 1'b1;
    step();
    check_out("b2b add", 19'd3, 3'b000, 1'b0, 1'b0);
    bus.ALUControl = OP_SUB; bus.A = 19'd2; bus.B = 19'd3;
    step();
    check_out("b2b sub", 19'h7FFFF, 3'b001, 1'b0, 1'b0);
    bus.start = 1'b0;
    step();
    check("b2b done drops", {31'b0, bus.done}, 0);

    launch(OP_DIV, 19'd100, 19'd7);
    wait_done(lat, bcnt);
    check("div latency", lat, 19);
    check("div busy cycles", bcnt, 18);
    check("div busy low at done", {31'b0, bus.busy}, 0);
    check_out("div 100/7", 19'd14, 3'b000, 1'b0, 1'b0);

    launch(OP_MOD, 19'd100, 19'd7);
    wait_done(lat, bcnt);
    check("mod latency", lat, 19);
    check_out("mod 100%7", 19'd2, 3'b000, 1'b0, 1'b0);

    launch(OP_DIV, 19'h12345, 19'd0);
    wait_done(lat, bcnt);
    check("div0 latency", lat, 19);
    check_out("div by 0", 19'h7FFFF, 3'b001, 1'b1, 1'b0);

    launch(OP_MOD, 19'h12345, 19'd0);
    wait_done(lat, bcnt);
    check("mod0 latency", lat, 19);
    check_out("mod by 0", 19'h12345, 3'b000, 1'b1, 1'b0);

    launch(OP_ADD, 19'd1, 19'd1);
    check_out("add clears dz", 19'd2, 3'b000, 1'b0, 1'b0);

    // A start during ITER with changed operands must be ignored entirely.
    launch(OP_DIV, 19'd1000, 19'd10);
    dn = 0; first = 0; both = 0;
    for (int i = 1; i <= 25; i++) begin
      if (i > 1) step();
      if (bus.done) begin
        dn++;
        if (first == 0) first = i;
      end
      if (bus.done && bus.busy) both++;
      if (i == 5) begin
        bus.ALUControl = OP_ADD; bus.A = 19'd1; bus.B = 19'd1; bus.start = 1'b1;
      end
      if (i == 6) bus.start = 1'b0;
    end
    check("ignored start done count", dn, 1);
    check("ignored start done cycle", first, 19);
    check("ignored start result", {13'b0, bus.Result}, 32'd100);
    check("done and busy overlap", both, 0);

    // Reset in the middle of a DIV abandons it with no later done.
    launch(OP_DIV, 19'd500, 19'd5);
    repeat (9) step();
    rst_n = 1'b0;
    #2;
    check("mid reset result", {13'b0, bus.Result},   0);
    check("mid reset flags",  {29'b0, bus.ALUFlags}, 0);
    check("mid reset dz",     {31'b0, bus.dz},       0);
    check("mid reset err",    {31'b0, bus.err},      0);
    check("mid reset busy",   {31'b0, bus.busy},     0);
    check("mid reset done",   {31'b0, bus.done},     0);
    step();
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.done) dn++;
    end
    check("no done after reset", dn, 0);
    check("busy stays low after reset", {31'b0, bus.busy}, 0);

    launch(OP_SHL, 19'd1, 19'd18);
    check_out("shl 18", 19'h40000, 3'b001, 1'b0, 1'b0);
    launch(OP_SHL, 19'd1, 19'd19);
    check_out("shl 19", 19'h0, 3'b100, 1'b0, 1'b0);
    launch(OP_SHR, 19'h40000, 19'd18);
    check_out("shr 18", 19'h1, 3'b000, 1'b0, 1'b0);
    launch(OP_SHR, 19'h7FFFF, 19'h7FFFF);
    check_out("shr huge", 19'h0, 3'b100, 1'b0, 1'b0);
    launch(OP_ILL, 19'd5, 19'd6);
    check_out("illegal op", 19'h0, 3'b000, 1'b0, 1'b1);
    launch(OP_ADD, 19'd2, 19'd3);
    check_out("add clears err", 19'd5, 3'b000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
